// File: rtl/mult_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mult_scheduler
// Purpose  : Round-robin shares one shift-add multiplier (one add per clock)
//            between two requesters. Optional macro MULT_EARLY_TERM_EN
//            ends iteration once no multiplier bits remain set.
// Revision : 1.0  initial release
// ============================================================================
module mult_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 busy
);

    localparam int c_KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_AW = c_KW + 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_id;
    logic                r_last_grant;
    logic [2*WIDTH-1:0]  r_acc;
    logic [2*WIDTH-1:0]  w_acc_next;
    logic [c_KW-1:0]     r_k;
    logic [c_AW-1:0]     w_base;
    logic [WIDTH-1:0]    w_row;
    logic [WIDTH:0]      w_sum;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_accept_id;
    logic                w_last;

    // Round-robin: on contention the requester not served last time wins.
    assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

    // Bits above k+WIDTH are still zero at iteration k, so the adder's carry
    // can be written straight into acc bit k+WIDTH.
    assign w_base = {1'b0, r_k};
    assign w_row  = r_b[r_k] ? r_a : '0;
    assign w_sum  = {1'b0, r_acc[w_base +: WIDTH]} + {1'b0, w_row};

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[w_base +: WIDTH+1] = w_sum;
    end

`ifdef MULT_EARLY_TERM_EN
    assign w_last = ((r_b >> r_k) >> 1) == '0;
`else
    assign w_last = (r_k == c_K_LAST);
`endif

    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        w_accept     = 1'b0;
        w_accept_id  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 | w_grant1) begin
                    w_accept     = 1'b1;
                    w_accept_id  = w_grant1;
                    w_state_next = S_ITER;
                end
            end
            S_ITER: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_acc        <= '0;
            r_k          <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a          <= w_accept_id ? req1_a : req0_a;
                r_b          <= w_accept_id ? req1_b : req0_b;
                r_id         <= w_accept_id;
                r_last_grant <= w_accept_id;
                r_acc        <= '0;
                r_k          <= '0;
            end else if (r_state == S_ITER) begin
                r_acc <= w_acc_next;
                r_k   <= r_k + c_KW'(1);
            end
        end
    end

    assign rsp_valid   = (r_state == S_DONE);
    assign rsp_id      = r_id;
    assign rsp_product = r_acc;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mult_scheduler
// Purpose  : Self-checking bench for mult_scheduler (both MULT_EARLY_TERM_EN builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_scheduler;

    localparam int WIDTH = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req0_valid = 1'b0;
    logic                req0_ready;
    logic [WIDTH-1:0]    req0_a = '0;
    logic [WIDTH-1:0]    req0_b = '0;
    logic                req1_valid = 1'b0;
    logic                req1_ready;
    logic [WIDTH-1:0]    req1_a = '0;
    logic [WIDTH-1:0]    req1_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic                rsp_id;
    logic [2*WIDTH-1:0]  rsp_product;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    // Reference state: last granted requester and each requester's pending op.
    bit m_last = 1'b1;
    bit p_v[2];
    int p_a[2];
    int p_b[2];

    mult_scheduler #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input int b);
        int l;
        l = WIDTH;
`ifdef MULT_EARLY_TERM_EN
        l = 1;
        for (int k = 0; k < WIDTH; k++) begin
            if (((b >> k) & 1) == 1) l = k + 1;
        end
`endif
        return l;
    endfunction

    task automatic apply();
        req0_valid = p_v[0];
        req0_a     = WIDTH'(p_a[0]);
        req0_b     = WIDTH'(p_b[0]);
        req1_valid = p_v[1];
        req1_a     = WIDTH'(p_a[1]);
        req1_b     = WIDTH'(p_b[1]);
    endtask

    task automatic set_req(input int r, input int a, input int b);
        p_v[r] = 1'b1;
        p_a[r] = a;
        p_b[r] = b;
    endtask

    // One full transaction: arbitration, latency, result, optional backpressure.
    task automatic issue(input int hold);
        int id, lat, ea, eb;
        apply();
        #1;
        if (p_v[0] && p_v[1]) id = m_last ? 0 : 1;
        else                  id = p_v[1] ? 1 : 0;
        check("ready0_arb", req0_ready, (id == 0) && p_v[0]);
        check("ready1_arb", req1_ready, (id == 1) && p_v[1]);
        ea = p_a[id];
        eb = p_b[id];
        @(posedge clk); #1;
        m_last = (id == 1);
        p_v[id] = 1'b0;
        apply();
        #1;
        check("busy_after_accept", busy, 1);
        check("ready0_busy", req0_ready, 0);
        check("ready1_busy", req1_ready, 0);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_latency(eb));
        check("product", rsp_product, ea * eb);
        check("rsp_id", rsp_id, id);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_product", rsp_product, ea * eb);
            check("hold_id", rsp_id, id);
            check("hold_ready0", req0_ready, 0);
            check("hold_ready1", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        p_a[0] = 0; p_a[1] = 0; p_b[0] = 0; p_b[1] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_product", rsp_product, 0);
        rst_n = 1'b1;

        // Single op with maximum operands
        set_req(0, 15, 15);
        issue(0);

        // Backpressure with a second request waiting
        set_req(1, 13, 11);
        set_req(0, 6, 7);
        issue(10);
        issue(0);

        // Abort mid-iteration
        set_req(0, 9, 6);
        apply();
        @(posedge clk); #1;
        p_v[0] = 1'b0;
        apply();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("abort_no_rsp", rsp_valid, 0);
        end
        set_req(0, 2, 3);
        issue(0);

        // Fairness: both requesters continuously valid
        set_req(0, 3, 5);
        set_req(1, 7, 2);
        for (int i = 0; i < 8; i++) begin
            issue(0);
            if (!p_v[0]) set_req(0, 3, 5);
            if (!p_v[1]) set_req(1, 7, 2);
        end
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;

`ifdef MULT_EARLY_TERM_EN
        set_req(0, 7, 0);
        issue(0);
        set_req(1, 11, 1);
        issue(0);
        set_req(0, 5, 8);
        issue(0);
`endif

        // Exhaustive operand sweep through a random requester
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_req(int'($urandom_range(0, 1)), a, b);
                issue(0);
            end
        end

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_v[r] && $urandom_range(0, 3) != 0)
                    set_req(r, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            if (!p_v[0] && !p_v[1])
                set_req(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            issue(int'($urandom_range(0, 2)));
        end
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        apply();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
